ecb_row_sequencer: RTL and testbench

// - Sequences one captured image row (from horizontal_sync) through a single-block ECB cipher core.
// - Splits the HSIZE-bit row into NBLK = HSIZE/BLOCK_SIZE blocks and issues them one at a time with the frame key.
// - Reassembles the results and hands the processed row to the writer stage.
// - Counts rows per frame and latches a fresh key (from the LFSR) at each frame start.

---
 rtl/ecb_row_sequencer_pkg.sv | 20 ++
 rtl/ecb_row_sequencer.sv | 99 +++++++++
 tb/tb_ecb_row_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ecb_row_sequencer_pkg.sv
// Shared definitions for the ECB row sequencer: state encoding, default geometry, counter sizing.
package ecb_row_sequencer_pkg;

  localparam int HSIZE_DEF      = 768;
  localparam int BLOCK_SIZE_DEF = 32;
  localparam int VSIZE_DEF      = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } seq_state_e;

  // Counter width for n states; never below 1 bit so a 1-entry count still elaborates.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ecb_row_sequencer.sv
// Feeds one captured row block-by-block through a single-block ECB core and hands the
// reassembled row to the writer; tracks rows per frame and latches the frame key at row 0.
module ecb_row_sequencer
  import ecb_row_sequencer_pkg::*;
#(
  parameter int HSIZE      = HSIZE_DEF,
  parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
  parameter int VSIZE      = VSIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  row_valid,
  input  logic [HSIZE-1:0]      row_data,
  output logic                  row_ready,
  input  logic [BLOCK_SIZE-1:0] key_in,
  output logic                  key_req,
  output logic                  blk_valid,
  output logic [BLOCK_SIZE-1:0] blk_data,
  output logic [BLOCK_SIZE-1:0] blk_key,
  input  logic                  blk_ready,
  input  logic                  res_valid,
  input  logic [BLOCK_SIZE-1:0] res_data,
  output logic                  out_valid,
  output logic [HSIZE-1:0]      out_row,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic                  proto_err
);

  localparam int NBLK = HSIZE / BLOCK_SIZE;
  localparam int BW   = cnt_w(NBLK);
  localparam int RW   = cnt_w(VSIZE);
  localparam logic [BW-1:0] BLK_LAST = BW'(NBLK - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(VSIZE - 1);

  if ((HSIZE % BLOCK_SIZE) != 0 || NBLK < 1) begin : g_geom_chk
    $error("ecb_row_sequencer: HSIZE must be a non-zero multiple of BLOCK_SIZE");
  end

  seq_state_e            state;
  logic [BW-1:0]         blk_idx;
  logic [RW-1:0]         row_cnt;
  logic [HSIZE-1:0]      row_buf;
  logic [BLOCK_SIZE-1:0] key_q;

  // Results overwrite their source slice in place, so the buffer becomes the output row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      blk_idx    <= '0;
      row_cnt    <= '0;
      row_buf    <= '0;
      key_q      <= '0;
      frame_done <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (res_valid && state != WAIT) proto_err <= 1'b1;
      case (state)
        IDLE: if (row_valid) begin
          row_buf <= row_data;
          blk_idx <= '0;
          state   <= ISSUE;
          if (row_cnt == '0) key_q <= key_in;
        end
        ISSUE: if (blk_ready) state <= WAIT;
        WAIT: if (res_valid) begin
          row_buf[blk_idx*BLOCK_SIZE +: BLOCK_SIZE] <= res_data;
          if (blk_idx == BLK_LAST) begin
            state <= EMIT;
          end else begin
            blk_idx <= blk_idx + BW'(1);
            state   <= ISSUE;
          end
        end
        EMIT: if (out_ready) begin
          state <= IDLE;
          if (row_cnt == ROW_LAST) begin
            row_cnt    <= '0;
            frame_done <= 1'b1;
          end else begin
            row_cnt <= row_cnt + RW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from the state register; key_req marks the key-latch cycle.
  assign row_ready = (state == IDLE);
  assign key_req   = (state == IDLE) && row_valid && (row_cnt == '0);
  assign blk_valid = (state == ISSUE);
  assign blk_data  = row_buf[blk_idx*BLOCK_SIZE +: BLOCK_SIZE];
  assign blk_key   = key_q;
  assign out_valid = (state == EMIT);
  assign out_row   = row_buf;

endmodule

// File: tb/tb_ecb_row_sequencer.sv
// Directed bench: table of whole-row transactions through an XOR cipher model, plus reset/stray-result sequence.
module tb_ecb_row_sequencer;

  localparam int HSIZE = 768;
  localparam int BS    = 32;
  localparam int VSIZE = 4;
  localparam int NBLK  = HSIZE / BS;

  logic clk = 1'b0;
  logic rst;
  logic row_valid, row_ready, key_req, blk_valid, blk_ready, res_valid;
  logic out_valid, out_ready, frame_done, proto_err;
  logic [HSIZE-1:0] row_data, out_row;
  logic [BS-1:0] key_in, blk_data, blk_key, res_data;

  logic c_blk_ready, c_res_valid, stray_rv;
  logic [BS-1:0] c_res_data;
  assign blk_ready = c_blk_ready;
  assign res_valid = c_res_valid | stray_rv;
  assign res_data  = c_res_data;

  always #5 clk = ~clk;

  ecb_row_sequencer #(.HSIZE(HSIZE), .BLOCK_SIZE(BS), .VSIZE(VSIZE)) dut (
    .clk(clk), .rst(rst),
    .row_valid(row_valid), .row_data(row_data), .row_ready(row_ready),
    .key_in(key_in), .key_req(key_req),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_key(blk_key), .blk_ready(blk_ready),
    .res_valid(res_valid), .res_data(res_data),
    .out_valid(out_valid), .out_row(out_row), .out_ready(out_ready),
    .frame_done(frame_done), .proto_err(proto_err)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Cipher model: ready after rdy_lat wait cycles, result res_lat cycles after the handshake, data^key.
  bit cip_en;
  int rdy_lat, res_lat, stab_err;
  initial begin : cipher
    bit busy, hs_next, last_wait;
    int cnt, wcnt;
    logic [BS-1:0] pend, last_d;
    busy = 0; hs_next = 0; last_wait = 0; cnt = 0; wcnt = 0; pend = '0; last_d = '0;
    stab_err = 0;
    c_blk_ready = 1'b0; c_res_valid = 1'b0; c_res_data = '0;
    forever begin
      @(posedge clk); #1;
      c_res_valid = 1'b0; c_blk_ready = 1'b0;
      if (!cip_en) begin
        busy = 0; hs_next = 0; wcnt = 0; last_wait = 0;
        continue;
      end
      if (hs_next) begin busy = 1; cnt = 1; hs_next = 0; end
      if (busy) begin
        if (cnt >= res_lat) begin c_res_valid = 1'b1; c_res_data = pend; busy = 0; end
        else cnt++;
      end else if (blk_valid) begin
        if (last_wait && blk_data !== last_d) stab_err++;
        if (wcnt >= rdy_lat) begin
          c_blk_ready = 1'b1; hs_next = 1; pend = blk_data ^ blk_key; wcnt = 0; last_wait = 0;
        end else begin
          wcnt++; last_wait = 1; last_d = blk_data;
        end
      end
    end
  end

  int kreq_cnt = 0, fd_cnt = 0;
  logic [BS-1:0] dlog[$], klog[$];
  always @(negedge clk) begin
    if (key_req) kreq_cnt++;
    if (frame_done) fd_cnt++;
    if (blk_valid && blk_ready) begin dlog.push_back(blk_data); klog.push_back(blk_key); end
  end

  function automatic logic [HSIZE-1:0] mk_row(input int pat);
    logic [HSIZE-1:0] r;
    r = '0;
    for (int k = 0; k < NBLK; k++)
      case (pat)
        0:       r[k*BS +: BS] = BS'(k);
        1:       r[k*BS +: BS] = BS'(k*3 + 7);
        default: r[k*BS +: BS] = ~BS'(k);
      endcase
    return r;
  endfunction

  function automatic logic [HSIZE-1:0] xor_row(input logic [HSIZE-1:0] d, input logic [BS-1:0] k);
    logic [HSIZE-1:0] r;
    for (int i = 0; i < NBLK; i++) r[i*BS +: BS] = d[i*BS +: BS] ^ k;
    return r;
  endfunction

  typedef struct {
    int          pat;
    logic [31:0] key;
    int          rdy;
    int          res;
    int          stall;
    logic [31:0] ekey;
    int          elat;
    int          ekreq;
    int          efd;
  } vec_t;

  task automatic run_row(input vec_t v, input string tag, input bit eperr);
    logic [HSIZE-1:0] din, dexp, snap;
    logic [BS-1:0] dblk;
    int base, k0, f0, s0, lat, bad, kbad, sbad;
    din = mk_row(v.pat);
    dexp = xor_row(din, v.ekey);
    base = dlog.size(); k0 = kreq_cnt; f0 = fd_cnt; s0 = stab_err;
    rdy_lat = v.rdy; res_lat = v.res;
    for (int i = 0; i < 100 && !row_ready; i++) begin @(posedge clk); #1; end
    key_in = v.key; row_data = din; row_valid = 1'b1;
    @(posedge clk); #1;
    row_valid = 1'b0; row_data = '0; key_in = 32'hDEAD_DEAD;
    lat = 1;
    while (!out_valid && lat < 3000) begin @(posedge clk); #1; lat++; end
    chk({tag, ":latency"}, lat, v.elat);
    chk({tag, ":key_req_pulses"}, kreq_cnt - k0, v.ekreq);
    chk({tag, ":blocks_issued"}, dlog.size() - base, NBLK);
    bad = 0; kbad = 0;
    for (int k = 0; k < NBLK; k++) begin
      dblk = din[k*BS +: BS];
      if (base + k >= dlog.size() || dlog[base+k] !== dblk) bad++;
      if (base + k >= klog.size() || klog[base+k] !== v.ekey) kbad++;
    end
    chk({tag, ":blk_data_order_errs"}, bad, 0);
    chk({tag, ":blk_key_errs"}, kbad, 0);
    chk({tag, ":blk_data_unstable"}, stab_err - s0, 0);
    chk({tag, ":out_row_ok"}, longint'(out_row === dexp), 1);
    snap = out_row; sbad = 0;
    for (int i = 0; i < v.stall; i++) begin
      row_valid = 1'b1; row_data = ~din;
      @(negedge clk);
      if (!out_valid || out_row !== snap || row_ready || key_req) sbad++;
      @(posedge clk); #1;
    end
    row_valid = 1'b0;
    if (v.stall > 0) chk({tag, ":stall_hold_errs"}, sbad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk({tag, ":frame_done_pulses"}, fd_cnt - f0, v.efd);
    chk({tag, ":back_to_idle"}, longint'(row_ready && !out_valid), 1);
    chk({tag, ":proto_err"}, longint'(proto_err), longint'(eperr));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vt[5];
    vec_t vr;
    int bad_rr, bad_v, bad_pe, base;

    vt[0] = '{pat:0, key:32'hA5A5_0001, rdy:0, res:1, stall:0,  ekey:32'hA5A5_0001, elat:49,  ekreq:1, efd:0};
    vt[1] = '{pat:0, key:32'h1234_5678, rdy:3, res:5, stall:0,  ekey:32'hA5A5_0001, elat:217, ekreq:0, efd:0};
    vt[2] = '{pat:1, key:32'h1234_5678, rdy:0, res:1, stall:20, ekey:32'hA5A5_0001, elat:49,  ekreq:0, efd:0};
    vt[3] = '{pat:2, key:32'h1234_5678, rdy:1, res:2, stall:0,  ekey:32'hA5A5_0001, elat:97,  ekreq:0, efd:1};
    vt[4] = '{pat:0, key:32'h0000_BEEF, rdy:0, res:1, stall:0,  ekey:32'h0000_BEEF, elat:49,  ekreq:1, efd:0};

    rst = 1'b1; row_valid = 1'b0; row_data = '0; key_in = '0; out_ready = 1'b0;
    stray_rv = 1'b0; cip_en = 1'b1; rdy_lat = 0; res_lat = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    bad_rr = 0; bad_v = 0; bad_pe = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!row_ready) bad_rr++;
      if (blk_valid || out_valid || key_req) bad_v++;
      if (proto_err) bad_pe++;
    end
    chk("idle:row_ready_low", bad_rr, 0);
    chk("idle:valid_high", bad_v, 0);
    chk("idle:proto_err", bad_pe, 0);
    chk("idle:frame_done_pulses", fd_cnt, 0);
    chk("idle:blk_key_reset", blk_key, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_row(vt[i], $sformatf("row%0d", i), 1'b0);

    // Reset while block 10 is outstanding (row_cnt is 1 here, so no key load on this row).
    base = dlog.size();
    rdy_lat = 0; res_lat = 3;
    key_in = 32'h1111_1111; row_data = mk_row(0); row_valid = 1'b1;
    @(posedge clk); #1;
    row_valid = 1'b0;
    for (int i = 0; i < 500 && (dlog.size() - base) < 11; i++) begin @(posedge clk); #1; end
    chk("rst:reached_wait_blk10", longint'(!blk_valid && !out_valid && (dlog.size() - base) == 11), 1);
    #1 cip_en = 1'b0; rst = 1'b1;
    #1;
    chk("rst:row_ready", longint'(row_ready), 1);
    chk("rst:valids", longint'({blk_valid, out_valid, key_req, frame_done}), 0);
    chk("rst:proto_err", longint'(proto_err), 0);
    chk("rst:buffers_cleared", longint'(out_row === '0 && blk_key === '0), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    stray_rv = 1'b1;
    @(posedge clk); #1;
    stray_rv = 1'b0;
    chk("stray:proto_err_set", longint'(proto_err), 1);
    chk("stray:still_idle", longint'(row_ready && !blk_valid), 1);
    #1 cip_en = 1'b1;
    @(posedge clk); #1;
    vr = '{pat:1, key:32'hC0DE_0005, rdy:0, res:1, stall:0, ekey:32'hC0DE_0005, elat:49, ekreq:1, efd:0};
    run_row(vr, "post_rst", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
